divide: RTL and testbench
=========================

# divide

Iterative 32-bit radix-2 restoring divider serving the execute stage of the five-stage CPU. It is the responder side of the execute stage's `begin`/`end` long-latency operation handshake, the same protocol the multiplier uses. It takes a dividend, a divisor and a signedness flag, and returns the quotient and remainder (DIV/DIVU semantics, destined for LO/HI). The execute stage holds the instruction until `div_end` pulses.

## Interface
- `DATA_W`, default 32: operand and result width; only 32 is supported.
- `clk`  in  1  system clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `div_begin`  in  1  level request, driven as `divide & EXE_valid`.
- `div_signed`  in  1  1 = DIV (two's complement), 0 = DIVU.
- `div_op1`  in  32  dividend, taken from ALU operand 1.
- `div_op2`  in  32  divisor, taken from ALU operand 2.
- `quotient`  out  32  quotient, goes to LO.
- `remainder`  out  32  remainder, goes to HI.
- `div_end`  out  1  one-cycle completion pulse.
- `div_busy`  out  1  high in BUSY and DONE.

## Operation
- FSM states:
  - IDLE:
    - `div_begin`=1 → latch |op1|, |op2|, sign of the quotient (op1[31]^op2[31] when signed) and sign of the remainder (op1[31] when signed); clear the 64-bit partial remainder and the 5-bit step counter → BUSY.
    - Otherwise stay in IDLE.
  - BUSY, one step per cycle:
    - Shift {rem,dvd} left by 1.
    - Compute trial = rem − divisor (33-bit).
    - If trial is non-negative: rem ← trial, new quotient bit 1. Otherwise new quotient bit 0.
    - Counter increments. After the step taken at counter=31 → DONE.
  - DONE: `div_end`=1 for exactly this cycle → IDLE unconditionally.
- Sign fixup is applied when entering DONE:
  - Quotient is negated if the quotient sign is set.
  - Remainder is negated if the remainder sign is set.
  - `quotient`/`remainder` are registered and hold their values until the next operation reaches DONE.
- Operands are sampled only in the IDLE start cycle. Later changes on `div_op*` and `div_signed` are ignored.
- Cancel: `div_begin`=0 in any BUSY cycle → IDLE next cycle. No `div_end`; result registers are not updated. This covers a flushed EXE stage.
- Divide by zero has a defined result, identical whether or not the fast path is compiled in:
  - Unsigned: q=0xFFFFFFFF, r=op1.
  - Signed: q = op1<0 ? 0x00000001 : 0xFFFFFFFF, r=op1.
- Signed overflow 0x80000000 / 0xFFFFFFFF: q=0x80000000, r=0. The magnitude arithmetic is unsigned 32-bit, so this falls out naturally.

## Timing
- Reset (async assert, sync release): state IDLE, counter 0, `quotient`=0, `remainder`=0, `div_end`=0, `div_busy`=0.
- Latency: `div_begin` sampled high in IDLE at cycle T → `div_end` high in cycle T+33, results valid in the same cycle.
- The execute stage retires the instruction in the `div_end` cycle. Its next instruction can raise `div_begin` in T+34, which is IDLE, and starts then. Back-to-back divides therefore cost 34 cycles each.
- `div_begin` high during DONE does not start a new operation.
- Reset asserted mid-operation → immediate IDLE; no `div_end` follows.

## Configuration
- `DIV_ZERO_FAST_EN`:
  - Defined: IDLE with `div_begin`=1 and op2=0 → DONE directly. `div_end` in T+1 with the divide-by-zero values above.
  - Undefined: divide by zero runs the full 32 steps. `div_end` in T+33 with identical values.

## Structure
- Shared CPU package holds:
  - the state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - `DIV_STEPS`=32;
  - the counter width of 5.
- No sub-module. FSM, datapath and sign fixup live in one module. The execute stage instantiates it next to `multiply` and ORs `~divide | div_end` into its over condition.

## Test plan
- Unsigned 7 / 2 (begin at T) → `div_end` at T+33, q=3, r=1; `div_busy` high T+1..T+33.
- Signed −7 / 2 (0xFFFFFFF9, 0x00000002) → q=0xFFFFFFFD, r=0xFFFFFFFF. Signed 7 / −2 → q=0xFFFFFFFD, r=1.
- Signed 0x80000000 / 0xFFFFFFFF → q=0x80000000, r=0. Unsigned 0xFFFFFFFF / 1 → q=0xFFFFFFFF, r=0.
- Divisor 0:
  - Unsigned op1=0x12345678 → q=0xFFFFFFFF, r=0x12345678.
  - Signed op1=0xFFFFFFF0 → q=1, r=0xFFFFFFF0.
  - Run with and without `DIV_ZERO_FAST_EN`; `div_end` must arrive at T+1 vs T+33 respectively.
- Cancel and reset:
  - Drop `div_begin` at T+10 → no `div_end`, results unchanged. Restart 100/7 at T+12 → `div_end` at T+45, q=14, r=2.
  - Assert `resetn`=0 at T+20 → all outputs 0 immediately.
- Back-to-back 9/4 then 20/3 with `div_begin` held high across → ends at T+33 (q=2,r=1) and T+67 (q=6,r=2); no start during DONE.

Source files
------------

// File: rtl/divide_pkg.sv
// divide_pkg: shared CPU constants for the iterative divider.
//   State encoding (IDLE/BUSY/DONE), number of restoring steps per divide
//   and the width of the step counter.
package divide_pkg;

    localparam int unsigned DIV_DATA_W = 32;
    localparam int unsigned DIV_STEPS  = 32;
    localparam int unsigned DIV_CNT_W  = 5;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/divide_if.sv
// divide_if: begin/end long-latency handshake between the execute stage
// (master) and the divider (slave).
//   div_begin  : level request, held until div_end
//   div_signed : 1 = DIV, 0 = DIVU
//   div_op1    : dividend
//   div_op2    : divisor
//   quotient   : result for LO
//   remainder  : result for HI
//   div_end    : one-cycle completion pulse
//   div_busy   : divider occupied (BUSY or DONE)
interface divide_if
    import divide_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
);

    logic              div_begin;
    logic              div_signed;
    logic [DATA_W-1:0] div_op1;
    logic [DATA_W-1:0] div_op2;
    logic [DATA_W-1:0] quotient;
    logic [DATA_W-1:0] remainder;
    logic              div_end;
    logic              div_busy;

    modport master (
        output div_begin, div_signed, div_op1, div_op2,
        input  quotient, remainder, div_end, div_busy
    );

    modport slave (
        input  div_begin, div_signed, div_op1, div_op2,
        output quotient, remainder, div_end, div_busy
    );

endinterface

// File: rtl/divide.sv
// divide: iterative radix-2 restoring divider (DIV/DIVU) for the execute
// stage. One quotient bit per cycle; div_end arrives 33 cycles after the
// start cycle. Dropping div_begin while busy cancels the operation.
//   clk    : system clock, rising edge
//   resetn : asynchronous active-low reset
//   dif    : divide_if.slave (request, operands, results, end/busy)
// Optional macro DIV_ZERO_FAST_EN: a zero divisor completes in one cycle
// with the same result the full iteration would produce.
module divide
    import divide_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
)
(
    input  logic    clk,
    input  logic    resetn,
    divide_if.slave dif
);

    logic [1:0]            state;
    logic [DIV_CNT_W-1:0]  cnt;
    logic [DATA_W-1:0]     divisor;
    logic [2*DATA_W-1:0]   acc;        // {partial remainder, dividend/quotient}
    logic                  q_neg;
    logic                  r_neg;
    logic [DATA_W-1:0]     q_r;
    logic [DATA_W-1:0]     r_r;

    logic                  op1_neg;
    logic                  op2_neg;
    logic [DATA_W-1:0]     op1_abs;
    logic [DATA_W-1:0]     op2_abs;
    logic [DATA_W:0]       trial;
    logic [2*DATA_W-1:0]   acc_step;
    logic [DATA_W-1:0]     q_fix;
    logic [DATA_W-1:0]     r_fix;
    logic                  last_step;

    always_comb begin
        op1_neg  = dif.div_signed & dif.div_op1[DATA_W-1];
        op2_neg  = dif.div_signed & dif.div_op2[DATA_W-1];
        op1_abs  = op1_neg ? -dif.div_op1 : dif.div_op1;
        op2_abs  = op2_neg ? -dif.div_op2 : dif.div_op2;

        // Shifted remainder is acc[2W-1:W-1]. Because rem < divisor, a
        // W+1-bit difference has its MSB set exactly when the shifted
        // remainder is smaller than the divisor.
        trial    = acc[2*DATA_W-1:DATA_W-1] - {1'b0, divisor};
        acc_step = trial[DATA_W] ? {acc[2*DATA_W-2:0], 1'b0}
                                 : {trial[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};

        q_fix    = q_neg ? -acc_step[DATA_W-1:0] : acc_step[DATA_W-1:0];
        r_fix    = r_neg ? -acc_step[2*DATA_W-1:DATA_W]
                         : acc_step[2*DATA_W-1:DATA_W];
        last_step = (cnt == DIV_CNT_W'(DIV_STEPS - 1));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            cnt     <= '0;
            divisor <= '0;
            acc     <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            q_r     <= '0;
            r_r     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dif.div_begin) begin
                        divisor <= op2_abs;
                        acc     <= {{DATA_W{1'b0}}, op1_abs};
                        q_neg   <= op1_neg ^ op2_neg;
                        r_neg   <= op1_neg;
                        cnt     <= '0;
`ifdef DIV_ZERO_FAST_EN
                        // Same values the 32-step iteration yields for a
                        // zero divisor after sign fixup.
                        if (dif.div_op2 == '0) begin
                            q_r   <= {{(DATA_W-1){~op1_neg}}, 1'b1};
                            r_r   <= dif.div_op1;
                            state <= DONE;
                        end else begin
                            state <= BUSY;
                        end
`else
                        state   <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    if (!dif.div_begin) begin
                        state <= IDLE;
                    end else begin
                        acc <= acc_step;
                        cnt <= cnt + 1'b1;
                        if (last_step) begin
                            q_r   <= q_fix;
                            r_r   <= r_fix;
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign dif.quotient  = q_r;
    assign dif.remainder = r_r;
    assign dif.div_end   = (state == DONE);
    assign dif.div_busy  = (state == BUSY) || (state == DONE);

endmodule

// File: tb/tb_divide.sv
// tb_divide: scoreboard bench for divide. Each started operation pushes
// its expected quotient/remainder and completion cycle; a negedge monitor
// pops and compares whenever div_end is seen.
module tb_divide;

    logic clk;
    logic resetn;
    int unsigned cyc;
    int unsigned n_chk;
    int unsigned n_err;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int unsigned cyc;
    } exp_t;

    exp_t sb[$];
    logic [31:0] last_q;
    logic [31:0] last_r;

    divide_if #(.DATA_W(32)) dif ();

    divide #(.DATA_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .dif    (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference DIV/DIVU semantics, returned as {quotient, remainder}.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = (s && a[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    // Negedge monitor: every div_end must match the oldest expectation.
    always @(negedge clk) begin
        if (resetn && dif.div_end) begin
            if (sb.size() == 0) begin
                check("spurious_end", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient",  dif.quotient,  e.q);
                check("remainder", dif.remainder, e.r);
                check("end_cycle", cyc, e.cyc);
            end
        end
    end

    // Called #1 after a posedge in an IDLE cycle; returns #1 after the
    // posedge that follows the DONE cycle.
    task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input bit hold, input bit scramble);
        exp_t        e;
        logic [63:0] qr;
        int unsigned lat;
        int unsigned busy_n;
        bit          seen;
        lat = 33;
`ifdef DIV_ZERO_FAST_EN
        if (b == 32'd0) lat = 1;
`endif
        qr     = ref_div(s, a, b);
        e.q    = qr[63:32];
        e.r    = qr[31:0];
        e.cyc  = cyc + lat;
        sb.push_back(e);
        last_q = e.q;
        last_r = e.r;
        dif.div_signed = s;
        dif.div_op1    = a;
        dif.div_op2    = b;
        dif.div_begin  = 1'b1;
        busy_n = 0;
        seen   = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (scramble) begin
                dif.div_signed = $urandom_range(0, 1);
                dif.div_op1    = $urandom;
                dif.div_op2    = $urandom;
            end
            if (dif.div_busy) busy_n++;
            if (dif.div_end) seen = 1'b1;
        end
        check("end_seen", 32'(seen), 32'd1);
        check("busy_cycles", busy_n, lat);
        if (!hold) dif.div_begin = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        cyc   = 0;
        resetn = 1'b0;
        dif.div_begin  = 1'b0;
        dif.div_signed = 1'b0;
        dif.div_op1    = '0;
        dif.div_op2    = '0;
        last_q = '0;
        last_r = '0;

        repeat (3) step();
        check("rst_quotient",  dif.quotient,  32'd0);
        check("rst_remainder", dif.remainder, 32'd0);
        check("rst_end",       32'(dif.div_end),  32'd0);
        check("rst_busy",      32'(dif.div_busy), 32'd0);
        resetn = 1'b1;
        step();

        // Plan vectors
        do_op(1'b0, 32'd7,          32'd2,          1'b0, 1'b0);
        do_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
        do_op(1'b1, 32'd7,          32'hFFFF_FFFE, 1'b0, 1'b0);
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op(1'b0, 32'hFFFF_FFFF, 32'd1,          1'b0, 1'b0);
        do_op(1'b0, 32'h1234_5678, 32'd0,          1'b0, 1'b0);
        do_op(1'b1, 32'hFFFF_FFF0, 32'd0,          1'b0, 1'b0);
        do_op(1'b1, 32'h8000_0000, 32'd0,          1'b0, 1'b0);
        do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b0, 1'b0);

        // Operands change after the start cycle and must be ignored
        do_op(1'b0, 32'd1000, 32'd7, 1'b0, 1'b1);

        // Back-to-back with div_begin held across DONE
        do_op(1'b0, 32'd9,  32'd4, 1'b1, 1'b0);
        do_op(1'b0, 32'd20, 32'd3, 1'b0, 1'b0);

        // Cancel at T+10, restart 100/7 at T+12
        dif.div_signed = 1'b0;
        dif.div_op1    = 32'd1000;
        dif.div_op2    = 32'd3;
        dif.div_begin  = 1'b1;
        repeat (10) step();
        dif.div_begin = 1'b0;
        step();
        check("cancel_busy",      32'(dif.div_busy), 32'd0);
        check("cancel_quotient",  dif.quotient,  last_q);
        check("cancel_remainder", dif.remainder, last_r);
        step();
        do_op(1'b0, 32'd100, 32'd7, 1'b0, 1'b0);

        // Random mix
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
            do_op(1'(i % 2), a, b, 1'b0, 1'b0);
        end

        // Reset in the middle of an operation at T+20
        dif.div_signed = 1'b0;
        dif.div_op1    = 32'd12345;
        dif.div_op2    = 32'd11;
        dif.div_begin  = 1'b1;
        repeat (20) step();
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_quotient",  dif.quotient,  32'd0);
        check("midrst_remainder", dif.remainder, 32'd0);
        check("midrst_end",       32'(dif.div_end),  32'd0);
        check("midrst_busy",      32'(dif.div_busy), 32'd0);
        dif.div_begin = 1'b0;
        step();
        resetn = 1'b1;
        repeat (40) step();

        check("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
